// File: rtl/decode_stage_if.sv
// Fetch/decode/execute signal bundle around the decode stage.
// slave: the decode stage itself; master: the surrounding pipeline.
interface decode_stage_if;
  // fetch side
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        ext_stall;
  logic        stall_fetch;
  logic        branch_judge;
  logic [31:0] branch_address;

  // register file side
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  // execute side
  logic        out_valid;
  logic [31:0] out_pc;
  logic [3:0]  out_alu_op;
  logic [31:0] out_src_a;
  logic [31:0] out_src_b;
  logic [31:0] out_store_data;
  logic [4:0]  out_dst;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;

  modport slave (
    input  in_valid, in_instr, in_pc, ext_stall, rs_data, rt_data,
    output stall_fetch, branch_judge, branch_address, rs_addr, rt_addr,
    output out_valid, out_pc, out_alu_op, out_src_a, out_src_b, out_store_data,
    output out_dst, out_reg_write, out_mem_read, out_mem_write
  );

  modport master (
    output in_valid, in_instr, in_pc, ext_stall, rs_data, rt_data,
    input  stall_fetch, branch_judge, branch_address, rs_addr, rt_addr,
    input  out_valid, out_pc, out_alu_op, out_src_a, out_src_b, out_store_data,
    input  out_dst, out_reg_write, out_mem_read, out_mem_write
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS integer-subset decode stage: decodes the fetched word, resolves
// branches/jumps in decode, inserts hazard bubbles with a small down-counter
// and registers the decode->execute bundle.
module decode_stage (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] store_data;
    logic [4:0]  dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } bundle_t;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [25:0] idx26;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;

  bundle_t     dec_b;
  logic [4:0]  dst_raw;
  logic        writes;
  logic        reads_rs;
  logic        reads_rt;
  logic        br_user;
  logic        br_taken;
  logic [31:0] br_target;

  bundle_t     out_q, out_d;
  logic [1:0]  stall_cnt_q, stall_cnt_d;
  logic        in_delay_q, in_delay_d;

  logic        ex_writes;
  logic        operand_hit;
  logic        load_hit;
  logic        alu_hit;
  logic [1:0]  hazard_cnt;
  logic [1:0]  stall_cnt;
  logic        hz_stall;
  logic        issue;
  logic        judge;

  assign opcode   = bus.in_instr[31:26];
  assign rs       = bus.in_instr[25:21];
  assign rt       = bus.in_instr[20:16];
  assign rd       = bus.in_instr[15:11];
  assign shamt    = bus.in_instr[10:6];
  assign funct    = bus.in_instr[5:0];
  assign imm16    = bus.in_instr[15:0];
  assign idx26    = bus.in_instr[25:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'h0000, imm16};
  assign pc_plus4 = bus.in_pc + 32'd4;
  assign pc_plus8 = bus.in_pc + 32'd8;

  assign bus.rs_addr = rs;
  assign bus.rt_addr = rt;

  // Instruction decode: operands, control flags, register usage and branch outcome.
  always_comb begin
    dec_b       = '0;
    dec_b.valid = 1'b1;
    dec_b.pc    = bus.in_pc;
    dst_raw     = 5'd0;
    writes      = 1'b0;
    reads_rs    = 1'b0;
    reads_rt    = 1'b0;
    br_user     = 1'b0;
    br_taken    = 1'b0;
    br_target   = 32'h0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            dec_b.src_a = bus.rs_data;
            dec_b.src_b = bus.rt_data;
            reads_rs    = 1'b1;
            reads_rt    = 1'b1;
            writes      = 1'b1;
            dst_raw     = rd;
            case (funct)
              F_SUBU:  dec_b.alu_op = ALU_SUB;
              F_AND:   dec_b.alu_op = ALU_AND;
              F_OR:    dec_b.alu_op = ALU_OR;
              F_XOR:   dec_b.alu_op = ALU_XOR;
              F_NOR:   dec_b.alu_op = ALU_NOR;
              F_SLT:   dec_b.alu_op = ALU_SLT;
              F_SLTU:  dec_b.alu_op = ALU_SLTU;
              default: dec_b.alu_op = ALU_ADD;
            endcase
          end
          F_SLL, F_SRL, F_SRA: begin
            dec_b.src_a  = bus.rt_data;
            dec_b.src_b  = {27'd0, shamt};
            dec_b.alu_op = (funct == F_SLL) ? ALU_SLL :
                           (funct == F_SRL) ? ALU_SRL : ALU_SRA;
            reads_rt     = 1'b1;
            writes       = 1'b1;
            dst_raw      = rd;
          end
          F_JR: begin
            reads_rs  = 1'b1;
            br_user   = 1'b1;
            br_taken  = 1'b1;
            br_target = bus.rs_data;
          end
          default: ;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        dec_b.src_a  = bus.rs_data;
        dec_b.src_b  = imm_sext;
        dec_b.alu_op = (opcode == OP_SLTI)  ? ALU_SLT :
                       (opcode == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
        reads_rs     = 1'b1;
        writes       = 1'b1;
        dst_raw      = rt;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_b.src_a  = bus.rs_data;
        dec_b.src_b  = imm_zext;
        dec_b.alu_op = (opcode == OP_ANDI) ? ALU_AND :
                       (opcode == OP_ORI)  ? ALU_OR : ALU_XOR;
        reads_rs     = 1'b1;
        writes       = 1'b1;
        dst_raw      = rt;
      end
      OP_LUI: begin
        dec_b.src_b  = {imm16, 16'h0000};
        dec_b.alu_op = ALU_LUI;
        writes       = 1'b1;
        dst_raw      = rt;
      end
      OP_LW: begin
        dec_b.src_a    = bus.rs_data;
        dec_b.src_b    = imm_sext;
        dec_b.mem_read = 1'b1;
        reads_rs       = 1'b1;
        writes         = 1'b1;
        dst_raw        = rt;
      end
      OP_SW: begin
        dec_b.src_a      = bus.rs_data;
        dec_b.src_b      = imm_sext;
        dec_b.store_data = bus.rt_data;
        dec_b.mem_write  = 1'b1;
        reads_rs         = 1'b1;
        reads_rt         = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        reads_rs  = 1'b1;
        reads_rt  = 1'b1;
        br_user   = 1'b1;
        br_taken  = (opcode == OP_BEQ) ? (bus.rs_data == bus.rt_data)
                                       : (bus.rs_data != bus.rt_data);
        br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
      end
      OP_J, OP_JAL: begin
        br_taken  = 1'b1;
        br_target = {pc_plus4[31:28], idx26, 2'b00};
        if (opcode == OP_JAL) begin
          dec_b.src_a = pc_plus8;
          writes      = 1'b1;
          dst_raw     = 5'd31;
        end
      end
      default: ;
    endcase
    // r0 as destination means no architectural write at all
    dec_b.dst       = (writes && dst_raw != 5'd0) ? dst_raw : 5'd0;
    dec_b.reg_write = writes && (dst_raw != 5'd0);
  end

  // Hazard detection against the bundle now in execute, stall/issue and branch resolution.
  always_comb begin
    ex_writes   = out_q.valid && out_q.reg_write && (out_q.dst != 5'd0);
    operand_hit = (reads_rs && rs == out_q.dst) || (reads_rt && rt == out_q.dst);
    load_hit    = ex_writes && out_q.mem_read && operand_hit;
    alu_hit     = ex_writes && !out_q.mem_read && operand_hit && br_user;
    hazard_cnt  = 2'd0;
    if (bus.in_valid) begin
      if (load_hit && br_user)       hazard_cnt = 2'd2;
      else if (load_hit || alu_hit)  hazard_cnt = 2'd1;
    end
    // a running countdown takes precedence; a fresh hazard loads it this cycle
    stall_cnt = (stall_cnt_q != 2'd0) ? stall_cnt_q : hazard_cnt;
    hz_stall  = (stall_cnt != 2'd0);
    issue     = bus.in_valid && !bus.ext_stall && !hz_stall;
    judge     = issue && br_taken && !in_delay_q;

    bus.stall_fetch    = !reset && (bus.ext_stall || hz_stall);
    bus.branch_judge   = !reset && judge;
    bus.branch_address = reset ? 32'h0 : br_target;
  end

  // Next-state for the execute bundle, stall counter and delay-slot flag.
  always_comb begin
    out_d       = out_q;
    stall_cnt_d = stall_cnt_q;
    in_delay_d  = in_delay_q;
    if (!bus.ext_stall) begin
      out_d       = issue ? dec_b : '0;
      stall_cnt_d = hz_stall ? (stall_cnt - 2'd1) : 2'd0;
      if (judge)      in_delay_d = 1'b1;
      else if (issue) in_delay_d = 1'b0;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      stall_cnt_q <= 2'd0;
      in_delay_q  <= 1'b0;
    end else begin
      out_q       <= out_d;
      stall_cnt_q <= stall_cnt_d;
      in_delay_q  <= in_delay_d;
    end
  end

  assign bus.out_valid      = out_q.valid;
  assign bus.out_pc         = out_q.pc;
  assign bus.out_alu_op     = out_q.alu_op;
  assign bus.out_src_a      = out_q.src_a;
  assign bus.out_src_b      = out_q.src_b;
  assign bus.out_store_data = out_q.store_data;
  assign bus.out_dst        = out_q.dst;
  assign bus.out_reg_write  = out_q.reg_write;
  assign bus.out_mem_read   = out_q.mem_read;
  assign bus.out_mem_write  = out_q.mem_write;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: each cycle's expected execute bundle is
// queued by the driver and checked by an independent monitor after the edge.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset;
  logic running = 1'b0;

  decode_stage_if bus();

  decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] store_data;
    logic [4:0]  dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } bundle_t;

  typedef struct {
    int      id;
    bundle_t b;
  } sb_item_t;

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  localparam bundle_t BUB = '0;

  function automatic bundle_t mk(input logic [31:0] pc, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] sd, input logic [4:0] dst,
                                 input logic rw, input logic mr, input logic mw);
    bundle_t r;
    r = '{1'b1, pc, op, a, b, sd, dst, rw, mr, mw};
    return r;
  endfunction

  function automatic bundle_t nop(input logic [31:0] pc);
    return mk(pc, 4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check32(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s id=%0d actual=%h required=%h", name, id, act, exp);
    end
  endtask

  // One decode cycle: drive at negedge, check combinational outputs, queue the bundle.
  task automatic step(input logic rst, input logic v, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd,
                      input logic ext, input bundle_t exp, input logic exp_sf,
                      input logic exp_bj, input logic [31:0] exp_ba, input int id);
    sb_item_t it;
    @(negedge clk);
    reset         = rst;
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.rs_data   = rsd;
    bus.rt_data   = rtd;
    bus.ext_stall = ext;
    #1;
    check32("stall_fetch", id, {31'd0, bus.stall_fetch}, {31'd0, exp_sf});
    check32("branch_judge", id, {31'd0, bus.branch_judge}, {31'd0, exp_bj});
    if (exp_bj || rst) check32("branch_address", id, bus.branch_address, exp_ba);
    if (!ext) begin
      it.id = id;
      it.b  = exp;
      sb_q.push_back(it);
    end
    running = 1'b1;
  endtask

  // Monitor: after every edge compare the registered bundle with the queued expectation.
  initial begin
    bundle_t  act;
    sb_item_t last;
    logic     held;
    last.id = 0;
    last.b  = '0;
    forever begin
      @(posedge clk);
      held = bus.ext_stall;
      #1;
      if (running) begin
        act = {bus.out_valid, bus.out_pc, bus.out_alu_op, bus.out_src_a, bus.out_src_b,
               bus.out_store_data, bus.out_dst, bus.out_reg_write, bus.out_mem_read,
               bus.out_mem_write};
        if (!held) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 required=1");
          end else begin
            last = sb_q.pop_front();
          end
        end
        checks++;
        if (act !== last.b) begin
          errors++;
          $display("FAIL %s id=%0d actual=%h required=%h",
                   held ? "hold" : "bundle", last.id, act, last.b);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.rs_data = '0; bus.rt_data = '0; bus.ext_stall = 1'b0;

    // reset with a jump presented: nothing may leak out
    step(1, 1, 32'h08000040, 32'h0, 0, 0, 0, BUB, 0, 0, 32'h0, 1);
    step(1, 1, 32'h08000040, 32'h0, 0, 0, 0, BUB, 0, 0, 32'h0, 2);

    // ALU decode
    step(0, 1, 32'h2402FFFF, 32'h100, 0, 0, 0,
         mk(32'h100, 0, 32'h0, 32'hFFFFFFFF, 0, 2, 1, 0, 0), 0, 0, 0, 10);
    step(0, 1, 32'h344700F0, 32'h104, 32'h12345678, 0, 0,
         mk(32'h104, 3, 32'h12345678, 32'hF0, 0, 7, 1, 0, 0), 0, 0, 0, 11);
    // load-use
    step(0, 1, 32'h8C230000, 32'h108, 32'h1000, 0, 0,
         mk(32'h108, 0, 32'h1000, 0, 0, 3, 1, 1, 0), 0, 0, 0, 12);
    step(0, 1, 32'h00632021, 32'h10C, 5, 6, 0, BUB, 1, 0, 0, 13);
    check32("rs_addr", 13, {27'd0, bus.rs_addr}, 32'd3);
    check32("rt_addr", 13, {27'd0, bus.rt_addr}, 32'd3);
    step(0, 1, 32'h00632021, 32'h10C, 5, 6, 0,
         mk(32'h10C, 0, 5, 6, 0, 4, 1, 0, 0), 0, 0, 0, 14);
    step(0, 1, 32'h00840023, 32'h110, 9, 3, 0,
         mk(32'h110, 1, 9, 3, 0, 0, 0, 0, 0), 0, 0, 0, 15);
    step(0, 1, 32'h00062903, 32'h114, 0, 32'h80000000, 0,
         mk(32'h114, 10, 32'h80000000, 4, 0, 5, 1, 0, 0), 0, 0, 0, 16);
    step(0, 1, 32'h3C08ABCD, 32'h118, 0, 0, 0,
         mk(32'h118, 11, 0, 32'hABCD0000, 0, 8, 1, 0, 0), 0, 0, 0, 17);
    step(0, 1, 32'h2829FFFE, 32'h11C, 7, 0, 0,
         mk(32'h11C, 6, 7, 32'hFFFFFFFE, 0, 9, 1, 0, 0), 0, 0, 0, 18);
    step(0, 1, 32'hAC490008, 32'h120, 32'h2000, 32'h55, 0,
         mk(32'h120, 0, 32'h2000, 8, 32'h55, 0, 0, 0, 1), 0, 0, 0, 19);
    // BEQ taken, BEQ in delay slot, BNE taken, bubble and J inside a delay slot
    step(0, 1, 32'h10220004, 32'h200, 32'h77, 32'h77, 0, nop(32'h200), 0, 1, 32'h214, 20);
    step(0, 1, 32'h10220004, 32'h204, 32'h77, 32'h77, 0, nop(32'h204), 0, 0, 0, 21);
    step(0, 1, 32'h1422FFFF, 32'h208, 1, 2, 0, nop(32'h208), 0, 1, 32'h208, 22);
    step(0, 0, 32'h0, 32'h20C, 0, 0, 0, BUB, 0, 0, 0, 23);
    step(0, 1, 32'h08000100, 32'h300, 0, 0, 0, nop(32'h300), 0, 0, 0, 24);
    // branch after load: two bubbles, then resolve
    step(0, 1, 32'h8C250000, 32'h400, 32'h40, 0, 0,
         mk(32'h400, 0, 32'h40, 0, 0, 5, 1, 1, 0), 0, 0, 0, 25);
    step(0, 1, 32'h14A00002, 32'h404, 3, 0, 0, BUB, 1, 0, 0, 26);
    step(0, 1, 32'h14A00002, 32'h404, 3, 0, 0, BUB, 1, 0, 0, 27);
    step(0, 1, 32'h14A00002, 32'h404, 3, 0, 0, nop(32'h404), 0, 1, 32'h410, 28);
    step(0, 1, 32'h240A0001, 32'h408, 0, 0, 0,
         mk(32'h408, 0, 0, 1, 0, 10, 1, 0, 0), 0, 0, 0, 29);
    // JAL, then ext_stall held three cycles on its delay slot
    step(0, 1, 32'h0C000040, 32'h00400010, 0, 0, 0,
         mk(32'h00400010, 0, 32'h00400018, 0, 0, 31, 1, 0, 0), 0, 1, 32'h100, 30);
    for (int i = 0; i < 3; i++)
      step(0, 1, 32'h240B0005, 32'h00400014, 0, 0, 1, BUB, 1, 0, 0, 31 + i);
    step(0, 1, 32'h240B0005, 32'h00400014, 0, 0, 0,
         mk(32'h00400014, 0, 0, 5, 0, 11, 1, 0, 0), 0, 0, 0, 34);
    // JR with hazard under ext_stall, then one bubble, then resolve
    step(0, 1, 32'h01600008, 32'h500, 32'h1234, 0, 1, BUB, 1, 0, 0, 35);
    step(0, 1, 32'h01600008, 32'h500, 32'h1234, 0, 0, BUB, 1, 0, 0, 36);
    step(0, 1, 32'h01600008, 32'h500, 32'h1234, 0, 0, nop(32'h500), 0, 1, 32'h1234, 37);
    step(0, 1, 32'hFC000000, 32'h504, 0, 0, 0, nop(32'h504), 0, 0, 0, 38);
    // reset in the middle of a two-cycle stall
    step(0, 1, 32'h8C250000, 32'h600, 32'h40, 0, 0,
         mk(32'h600, 0, 32'h40, 0, 0, 5, 1, 1, 0), 0, 0, 0, 39);
    step(0, 1, 32'h10A50001, 32'h604, 1, 1, 0, BUB, 1, 0, 0, 40);
    step(1, 1, 32'h10A50001, 32'h604, 1, 1, 0, BUB, 0, 0, 32'h0, 41);
    step(0, 1, 32'h2402FFFF, 32'h700, 0, 0, 0,
         mk(32'h700, 0, 0, 32'hFFFFFFFF, 0, 2, 1, 0, 0), 0, 0, 0, 42);
    // J, then JAL in its delay slot: no redirect but r31 still written
    step(0, 1, 32'h08000000, 32'h704, 0, 0, 0, nop(32'h704), 0, 1, 32'h0, 43);
    step(0, 1, 32'h0C000040, 32'h708, 0, 0, 0,
         mk(32'h708, 0, 32'h710, 0, 0, 31, 1, 0, 0), 0, 0, 0, 44);

    @(negedge clk);
    running = 1'b0;
    check32("scoreboard_drained", 0, sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

MIPS decode stage, directly downstream of fetch. It takes the fetched instruction word and PC and decodes the integer subset. It reads the register file, resolves branches and jumps in decode (feeding `branch_judge`/`branch_address` back to fetch) and detects load-use and branch-operand hazards with a stall counter. Results go into a registered decode→execute bundle.

## Interface

- No parameters.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  fetch bundle valid
- `in_instr`  in  32  fetched instruction
- `in_pc`  in  32  PC of `in_instr`
- `ext_stall`  in  1  downstream stall; hold all output registers
- `rs_addr` / `rt_addr`  out  5  register-file read addresses (combinational, `in_instr[25:21]` / `[20:16]`)
- `rs_data` / `rt_data`  in  32  register-file read data, already bypassed by the external forwarding unit
- `stall_fetch`  out  1  fetch must hold PC and instruction this cycle
- `branch_judge`  out  1  taken branch/jump resolved this cycle (combinational)
- `branch_address`  out  32  target, valid when `branch_judge`=1
- `out_valid`  out  1  execute bundle valid
- `out_pc`  out  32  PC
- `out_alu_op`  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI
- `out_src_a`, `out_src_b`  out  32  ALU operands
- `out_store_data`  out  32  rt value for SW
- `out_dst`  out  5  destination register; 0 means no write
- `out_reg_write`, `out_mem_read`, `out_mem_write`  out  1  control flags

## Operation

- **Decoded R-type:** ADDU SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA JR.
- **Decoded I/J-type:** ADDIU ANDI ORI XORI LUI SLTI SLTIU LW SW BEQ BNE J JAL.
- **Unknown opcode/funct:** emitted as a valid NOP (all write/mem flags 0).
- **Operands:**
  - R-type: a=rs, b=rt; dst=rd.
  - Shifts: a=rt, b=zero-extended shamt.
  - ADDIU/SLTI/SLTIU/LW/SW: b=sign-extended imm16.
  - ANDI/ORI/XORI: b=zero-extended imm16.
  - LUI: b={imm16,16'h0}.
  - I-type dst=rt.
  - JAL: a=pc+8, b=0, ADD, dst=31.
  - dst forced to 0 when the decoded dst is r0.
- **Branch targets:**
  - BEQ/BNE: pc+4+(sext(imm16)<<2), taken on rs==rt / rs!=rt.
  - J/JAL: {pc+4[31:28], idx26, 2'b00}, always taken.
  - JR: rs_data, always taken.
- **Delay slot:** an internal `in_delay` flag is set on the clock edge after `branch_judge`=1. It clears when the next valid, unstalled instruction is accepted. A branch/jump decoded while `in_delay`=1 does not assert `branch_judge` and still decodes as a NOP-branch (JAL in a delay slot still writes r31).
- **Hazard stall counter `stall_cnt` (2 bits), loaded when a valid instruction first enters decode with `stall_cnt`=0:**
  - Load-use: registered output has `out_valid`&`out_mem_read`&`out_dst`≠0 and the current instruction reads `out_dst`. Load value is 1.
  - Branch/JR operand is produced by a non-load instruction in execute. Load value is 1.
  - Branch/JR operand is produced by a load in execute. Load value is 2.
  - "Reads" means rs for all users of rs, rt for R-type, SW, BEQ and BNE.
  - While `stall_cnt`≠0: `stall_fetch`=1, `branch_judge`=0, a bubble (`out_valid`=0) is written, and the counter decrements.
  - The instruction issues on the cycle the counter reaches 0 and no hazard remains.
- **`ext_stall`=1:** output registers hold, `stall_fetch`=1, `branch_judge`=0, `stall_cnt` frozen.

## Timing

- **Reset:** all `out_*` = 0, `in_delay`=0, `stall_cnt`=0. `stall_fetch`, `branch_judge` and `branch_address` are 0 while `reset` is high.
- **Latency:** decode→execute bundle is 1 cycle (registered on the clk edge). `branch_judge`/`branch_address` are combinational, same cycle the branch is in decode. Fetch consumes them at the next edge.
- **`in_valid`=0:** a bubble is written; it raises no hazard and causes no `in_delay` change.
- **Simultaneous events:**
  - `ext_stall` and a hazard in the same cycle: `ext_stall` has priority and the counter does not load.
  - Hazard and a taken branch in the same cycle: the branch waits; `branch_judge` asserts only on the issue cycle, exactly once per branch.
- **Reset mid-stall:** the counter clears and the pending instruction is dropped.

## Test plan

- **ALU decode:** ADDIU r2,r0,0xFFFF at pc 0x100 → next cycle `out_valid`=1, `out_pc`=0x100, `out_alu_op`=0, `out_src_b`=0xFFFFFFFF, `out_dst`=2, `out_reg_write`=1.
- **Load-use:** LW r3,0(r1) then ADDU r4,r3,r3 → `stall_fetch`=1 for one cycle, one bubble, ADDU issues on the following cycle.
- **BEQ taken:** BEQ at 0x200 with rs_data==rt_data, imm=0x0004 → same cycle `branch_judge`=1, `branch_address`=0x214. The next instruction has `in_delay`=1; a BEQ there gives `branch_judge`=0.
- **Branch after load:** LW r5 then BNE r5,r0 → 2 stall cycles, 2 bubbles, then `branch_judge` is evaluated on the issue cycle.
- **JAL/JR:**
  - JAL idx=0x40 at 0x0040_0010 → `branch_address`=0x0000_0100; bundle has `out_src_a`=0x0040_0018, `out_dst`=31.
  - JR with rs_data=0x1234 → `branch_address`=0x1234.
- **Stall priority / reset:** `ext_stall` held 3 cycles → outputs unchanged, `stall_fetch`=1. Reset during `stall_cnt`=2 → all outputs 0 the next cycle.
